// File: rtl/display_list_sequencer.sv
// -----------------------------------------------------------------------------
// display_list_sequencer
//
// Walks a display list held in an external RAM and turns it into line-segment
// requests for a line drawer. Each list word carries a point and two flags:
//   word[17:10] x, word[9:2] y, word[1] line, word[0] pos
//   pos only   : move the pen to (x,y)
//   line only  : draw pen -> (x,y), pen becomes (x,y)
//   line + pos : end of list
//   neither    : no-op
// A word counter guards against lists with no end marker. When it runs out,
// frame_err is set and stays set until rst.
//
// The writer is held off with halt=1. halt drops for exactly one cycle when the
// sequencer hands the RAM back. The sequencer then waits for go to fall, so a
// go left high never starts a second frame.
//
// Optional build macro: DISPLAY_DOUBLE_BUFFER_EN
//   Undefined (default): single buffer. Draw on go, release the writer when the
//     frame is done. bank_sel is always 0.
//   Defined: on go the bank is flipped and the writer is released at once. The
//     freshly written bank is drawn while the writer fills the other one.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   go         in   writer has finished the list
//   halt       out  hold to the writer, 0 = released (one-cycle pulse)
//   adrREAD    out  RAM read address
//   dataREAD   in   RAM data, valid one cycle after adrREAD
//   bank_sel   out  RAM bank being read
//   x0/y0      out  segment start
//   x1/y1      out  segment end
//   draw_start out  one-cycle segment request
//   draw_busy  in   line drawer active
//   frame_err  out  sticky runaway-list flag
// -----------------------------------------------------------------------------
module display_list_sequencer #(
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned ADR_WIDTH = 16,
    parameter int unsigned DATAWIDTH = 18,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    output logic                 halt,
    output logic [ADR_WIDTH-1:0] adrREAD,
    input  logic [DATAWIDTH-1:0] dataREAD,
    output logic                 bank_sel,
    output logic [OUT_WIDTH-1:0] x0,
    output logic [OUT_WIDTH-1:0] y0,
    output logic [OUT_WIDTH-1:0] x1,
    output logic [OUT_WIDTH-1:0] y1,
    output logic                 draw_start,
    input  logic                 draw_busy,
    output logic                 frame_err
);

    // Wide enough to hold MAX_WORDS itself, because that is the terminal count.
    localparam int unsigned CntWidth = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWaitData,
        StDecode,
        StIssue,
        StWaitLine,
        StRelease,
        StRearm
    } state_e;

    state_e                 state_q, state_d;
    logic [ADR_WIDTH-1:0]   adr_q, adr_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]   pen_x_q, pen_x_d;
    logic [OUT_WIDTH-1:0]   pen_y_q, pen_y_d;
    logic [OUT_WIDTH-1:0]   x0_q, x0_d;
    logic [OUT_WIDTH-1:0]   y0_q, y0_d;
    logic [OUT_WIDTH-1:0]   x1_q, x1_d;
    logic [OUT_WIDTH-1:0]   y1_q, y1_d;
    logic                   bank_q, bank_d;
    logic                   err_q, err_d;
    // Set on entry to WAIT_LINE. The drawer gets one cycle to raise draw_busy
    // before the low level of draw_busy is trusted as "segment done".
    logic                   wl_first_q, wl_first_d;

    // Word fields. The fields sit at fixed offsets from bit 0.
    logic [OUT_WIDTH-1:0]   word_x;
    logic [OUT_WIDTH-1:0]   word_y;
    logic                   word_line;
    logic                   word_pos;

    assign word_x    = dataREAD[2 + OUT_WIDTH +: OUT_WIDTH];
    assign word_y    = dataREAD[2 +: OUT_WIDTH];
    assign word_line = dataREAD[1];
    assign word_pos  = dataREAD[0];

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        cnt_d      = cnt_q;
        pen_x_d    = pen_x_q;
        pen_y_d    = pen_y_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        bank_d     = bank_q;
        err_d      = err_q;
        wl_first_d = wl_first_q;
        draw_start = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (go && !draw_busy) begin
                    adr_d = '0;
                    cnt_d = '0;
`ifdef DISPLAY_DOUBLE_BUFFER_EN
                    // Hand the written bank over for drawing and free the
                    // writer immediately so it can fill the other bank.
                    bank_d  = ~bank_q;
                    state_d = StRelease;
`else
                    state_d = StFetch;
`endif
                end
            end

            StFetch: begin
                // The runaway check is placed here so that every path that
                // consumes a word (move, line, no-op) passes through it.
                if (cnt_q == CntWidth'(MAX_WORDS)) begin
                    err_d = 1'b1;
`ifdef DISPLAY_DOUBLE_BUFFER_EN
                    // The writer was already released at frame start.
                    state_d = StIdle;
`else
                    state_d = StRelease;
`endif
                end else begin
                    state_d = StWaitData;
                end
            end

            StWaitData: begin
                state_d = StDecode;
            end

            StDecode: begin
                unique case ({word_line, word_pos})
                    2'b01: begin
                        pen_x_d = word_x;
                        pen_y_d = word_y;
                        adr_d   = adr_q + ADR_WIDTH'(1);
                        cnt_d   = cnt_q + CntWidth'(1);
                        state_d = StFetch;
                    end
                    2'b10: begin
                        x0_d    = pen_x_q;
                        y0_d    = pen_y_q;
                        x1_d    = word_x;
                        y1_d    = word_y;
                        pen_x_d = word_x;
                        pen_y_d = word_y;
                        state_d = StIssue;
                    end
                    2'b11: begin
`ifdef DISPLAY_DOUBLE_BUFFER_EN
                        state_d = StIdle;
`else
                        state_d = StRelease;
`endif
                    end
                    2'b00: begin
                        // No-op words still count toward the runaway guard.
                        adr_d   = adr_q + ADR_WIDTH'(1);
                        cnt_d   = cnt_q + CntWidth'(1);
                        state_d = StFetch;
                    end
                endcase
            end

            StIssue: begin
                if (!draw_busy) begin
                    draw_start = 1'b1;
                    wl_first_d = 1'b1;
                    state_d    = StWaitLine;
                end
            end

            StWaitLine: begin
                if (wl_first_q) begin
                    wl_first_d = 1'b0;
                end else if (!draw_busy) begin
                    adr_d   = adr_q + ADR_WIDTH'(1);
                    cnt_d   = cnt_q + CntWidth'(1);
                    state_d = StFetch;
                end
            end

            StRelease: begin
                state_d = StRearm;
            end

            StRearm: begin
                if (!go) begin
`ifdef DISPLAY_DOUBLE_BUFFER_EN
                    state_d = StFetch;
`else
                    state_d = StIdle;
`endif
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            adr_q      <= '0;
            cnt_q      <= '0;
            pen_x_q    <= '0;
            pen_y_q    <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            bank_q     <= 1'b0;
            err_q      <= 1'b0;
            wl_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            cnt_q      <= cnt_d;
            pen_x_q    <= pen_x_d;
            pen_y_q    <= pen_y_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            bank_q     <= bank_d;
            err_q      <= err_d;
            wl_first_q <= wl_first_d;
        end
    end

    assign halt      = (state_q != StRelease);
    assign adrREAD   = adr_q;
    assign bank_sel  = bank_q;
    assign x0        = x0_q;
    assign y0        = y0_q;
    assign x1        = x1_q;
    assign y1        = y1_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_display_list_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for display_list_sequencer.
// A list-level model walks the RAM contents and produces the segment queue the
// drawer should receive. A negedge monitor checks every draw request, every
// release pulse, bank_sel and frame_err against that model. Directed frames
// also carry literal expectations.
// -----------------------------------------------------------------------------
module tb_display_list_sequencer;

    localparam int unsigned MaxW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        halt;
    logic [15:0] adrREAD;
    logic [17:0] dataREAD;
    logic        bank_sel;
    logic [7:0]  x0, y0, x1, y1;
    logic        draw_start;
    logic        draw_busy;
    logic        frame_err;

    display_list_sequencer #(
        .OUT_WIDTH(8),
        .ADR_WIDTH(16),
        .DATAWIDTH(18),
        .MAX_WORDS(MaxW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .halt      (halt),
        .adrREAD   (adrREAD),
        .dataREAD  (dataREAD),
        .bank_sel  (bank_sel),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .draw_start(draw_start),
        .draw_busy (draw_busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Two-bank list RAM with a one-cycle read latency.
    logic [17:0] mem0 [64];
    logic [17:0] mem1 [64];
    always @(posedge clk) dataREAD <= bank_sel ? mem1[adrREAD[5:0]] : mem0[adrREAD[5:0]];

    int n_cmp = 0;
    int n_fail = 0;

    // Model state
    logic [31:0] exp_q [$];
    logic [7:0]  pen_x = 8'd0;
    logic [7:0]  pen_y = 8'd0;
    bit          err_possible = 1'b0;
    bit          err_sticky = 1'b0;
    bit          bank_par = 1'b0;
    logic [31:0] last_seg = 32'd0;

    // Observations
    int          rel_cnt = 0;
    int          start_cnt = 0;
    logic [31:0] cap [16];
    int          cap_n = 0;
    bit          mon_en = 1'b0;
    logic        prev_halt = 1'b1;

    // Drawer model
    int          busy_len = 5;
    int          rem = 0;
    bit          force_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] mk(input logic [7:0] x, input logic [7:0] y,
                                       input logic ln, input logic ps);
        return {x, y, ln, ps};
    endfunction

    // Walk the list the way the rules describe it, starting at address 0.
    task automatic plan_frame(input bit bank);
        logic [17:0] w;
        bit done = 1'b0;
        for (int a = 0; a < int'(MaxW) && !done; a++) begin
            w = bank ? mem1[a] : mem0[a];
            case (w[1:0])
                2'b01: begin pen_x = w[17:10]; pen_y = w[9:2]; end
                2'b10: begin
                    exp_q.push_back({pen_x, pen_y, w[17:10], w[9:2]});
                    pen_x = w[17:10];
                    pen_y = w[9:2];
                end
                2'b11: done = 1'b1;
                default: ;
            endcase
        end
        if (!done) err_possible = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            mem0[i] = 18'd0;
            mem1[i] = 18'd0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_halt"}, halt, 1);
        check({tag, "_draw_start"}, draw_start, 0);
        check({tag, "_adr"}, adrREAD, 0);
        check({tag, "_coords"}, {x0, y0, x1, y1}, 0);
        check({tag, "_bank"}, bank_sel, 0);
        check({tag, "_err"}, frame_err, 0);
    endtask

    task automatic wait_release(input string name);
        int  r0 = rel_cnt;
        bit  seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk); #1;
            if (rel_cnt != r0) seen = 1'b1;
        end
        check({name, "_release_seen"}, seen, 1);
    endtask

    task automatic run_frame(input string name, input bit hold_go);
        go = 1'b1;
        wait_release(name);
        if (!hold_go) begin
            go = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
        end
    endtask

    // Drawer: busy for busy_len cycles after each accepted draw_start.
    initial begin
        int seen_starts = 0;
        draw_busy = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (start_cnt != seen_starts) begin
                seen_starts = start_cnt;
                rem = busy_len;
            end else if (rem > 0) begin
                rem--;
            end
            draw_busy = (rem > 0) || force_busy;
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (mon_en) begin
            if (!halt) begin
                check("halt_pulse_one_cycle", prev_halt, 1);
                rel_cnt++;
`ifdef DISPLAY_DOUBLE_BUFFER_EN
                bank_par = ~bank_par;
`endif
                check("err_at_release", frame_err, err_sticky | err_possible);
                err_sticky   = err_sticky | err_possible;
                err_possible = 1'b0;
            end
            prev_halt = halt;
            check("bank_sel", bank_sel, bank_par);
            if (err_sticky) check("err_sticky", frame_err, 1);
            else if (!err_possible) check("err_clear", frame_err, 0);
            if (draw_start) begin
                start_cnt++;
                check("start_while_busy", draw_busy, 0);
                check("segment_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("segment", {x0, y0, x1, y1}, exp_q.pop_front());
                end
                last_seg = {x0, y0, x1, y1};
                if (cap_n < 16) cap[cap_n] = {x0, y0, x1, y1};
                cap_n++;
            end
            if (rem > 0 && draw_busy) check("coords_stable", {x0, y0, x1, y1}, last_seg);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int r0;
        bit seen;
        rst = 1'b1;
        go = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
        mon_en = 1'b1;
        @(posedge clk); #1;

`ifdef DISPLAY_DOUBLE_BUFFER_EN
        // Frame 1 is read from bank 1, frame 2 from bank 0.
        mem1[0] = mk(8'd5, 8'd5, 1'b0, 1'b1);
        mem1[1] = mk(8'd9, 8'd9, 1'b1, 1'b0);
        mem1[2] = mk(8'd0, 8'd0, 1'b1, 1'b1);
        mem0[0] = mk(8'd1, 8'd1, 1'b1, 1'b0);
        mem0[1] = mk(8'd0, 8'd0, 1'b1, 1'b1);
        for (int f = 0; f < 2; f++) begin
            plan_frame((f == 0) ? 1'b1 : 1'b0);
            run_frame("db_frame", 1'b0);
            seen = 1'b0;
            for (int i = 0; i < 400 && !seen; i++) begin
                @(posedge clk); #1;
                if (exp_q.size() == 0) seen = 1'b1;
            end
            check("db_drained", seen, 1);
            repeat (15) begin @(posedge clk); #1; end
            check("db_bank_after_frame", bank_sel, (f == 0) ? 1 : 0);
        end
        check("db_release_total", rel_cnt, 2);
        check("db_seg0", cap[0], {8'd5, 8'd5, 8'd9, 8'd9});
        check("db_seg1", cap[1], {8'd9, 8'd9, 8'd1, 8'd1});
        check("db_seg_count", cap_n, 2);
`else
        // Two segments, drawer busy 5 cycles each.
        mem0[0] = mk(8'd10, 8'd10, 1'b0, 1'b1);
        mem0[1] = mk(8'd50, 8'd10, 1'b1, 1'b0);
        mem0[2] = mk(8'd50, 8'd40, 1'b1, 1'b0);
        mem0[3] = mk(8'd0, 8'd0, 1'b1, 1'b1);
        plan_frame(1'b0);
        run_frame("two_seg", 1'b0);
        check("two_seg_starts", start_cnt, 2);

        // Drawer held busy while the request waits in ISSUE.
        clear_mem();
        mem0[0] = mk(8'd20, 8'd30, 1'b1, 1'b0);
        mem0[1] = mk(8'd0, 8'd0, 1'b1, 1'b1);
        plan_frame(1'b0);
        s0 = start_cnt;
        go = 1'b1;
        @(posedge clk); #1;
        force_busy = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        check("busy_hold_no_start", start_cnt, s0);
        check("busy_hold_adr", adrREAD, 0);
        force_busy = 1'b0;
        wait_release("busy_hold");
        go = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("busy_hold_one_start", start_cnt, s0 + 1);

        // No end marker: runaway after MaxW words.
        for (int i = 0; i < 64; i++) mem0[i] = mk(8'(3 * i), 8'(i + 1), 1'b0, 1'b1);
        plan_frame(1'b0);
        go = 1'b1;
        wait_release("runaway");
        check("runaway_adr", adrREAD, MaxW);
        check("runaway_err", frame_err, 1);
        go = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // go held high after release must not start another frame.
        clear_mem();
        mem0[0] = mk(8'd100, 8'd200, 1'b1, 1'b0);
        mem0[1] = mk(8'd0, 8'd0, 1'b1, 1'b1);
        plan_frame(1'b0);
        run_frame("stale_go", 1'b1);
        r0 = rel_cnt;
        s0 = start_cnt;
        repeat (30) begin @(posedge clk); #1; end
        check("stale_go_no_release", rel_cnt, r0);
        check("stale_go_no_start", start_cnt, s0);
        go = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        plan_frame(1'b0);
        run_frame("rego", 1'b0);
        check("rego_start", start_cnt, s0 + 1);
        check("err_still_set", frame_err, 1);

        // Reset while the first segment is being drawn.
        clear_mem();
        mem0[0] = mk(8'd1, 8'd2, 1'b0, 1'b1);
        mem0[1] = mk(8'd3, 8'd4, 1'b1, 1'b0);
        mem0[2] = mk(8'd5, 8'd6, 1'b1, 1'b0);
        mem0[3] = mk(8'd0, 8'd0, 1'b1, 1'b1);
        plan_frame(1'b0);
        s0 = start_cnt;
        go = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (start_cnt != s0) seen = 1'b1;
        end
        check("mid_seg_start_seen", seen, 1);
        rst = 1'b1;
        go = 1'b0;
        mon_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_seg_reset");
        exp_q.delete();
        pen_x = 8'd0;
        pen_y = 8'd0;
        err_sticky = 1'b0;
        err_possible = 1'b0;
        last_seg = 32'd0;
        prev_halt = 1'b1;
        mon_en = 1'b1;
        plan_frame(1'b0);
        @(posedge clk); #1;
        // Drawer is still busy from the aborted segment, so IDLE must wait.
        s0 = start_cnt;
        go = 1'b1;
        @(posedge clk); #1;
        check("idle_wait_busy_adr", adrREAD, 0);
        check("idle_wait_busy_start", start_cnt, s0);
        wait_release("after_reset");
        go = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        check("release_total", rel_cnt, 6);
        check("seg_count", cap_n, 8);
        check("seg0", cap[0], {8'd10, 8'd10, 8'd50, 8'd10});
        check("seg1", cap[1], {8'd50, 8'd10, 8'd50, 8'd40});
        check("seg2", cap[2], {8'd50, 8'd40, 8'd20, 8'd30});
        check("seg3", cap[3], {8'd21, 8'd8, 8'd100, 8'd200});
        check("seg4", cap[4], {8'd100, 8'd200, 8'd100, 8'd200});
        check("seg6", cap[6], {8'd1, 8'd2, 8'd3, 8'd4});
        check("seg7", cap[7], {8'd3, 8'd4, 8'd5, 8'd6});
`endif
        check("all_segments_drawn", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/display_list_sequencer.md
DISPLAY_LIST_SEQUENCER -- requirements
Module: display_list_sequencer

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 8, coordinate width.
REQ-002 SHALL have parameter ADR_WIDTH, default 16, display-list RAM address width.
REQ-003 SHALL have parameter DATAWIDTH, default 18, list word width: x[17:10], y[9:2], line[1], pos[0].
REQ-004 SHALL have parameter MAX_WORDS, default 1024, runaway guard on words per frame.
REQ-005 SHALL use one clock; reset is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-006 SHALL have these ports:
- go, input, 1 bit: list writer has completed the list.
- halt, output, 1 bit: hold to list writer; 0 = release.
- adrREAD, output, ADR_WIDTH bits: RAM read address.
- dataREAD, input, DATAWIDTH bits: RAM data, valid one cycle after adrREAD.
- bank_sel, output, 1 bit: RAM bank being read.
- x0, y0, output, OUT_WIDTH bits each: segment start.
- x1, y1, output, OUT_WIDTH bits each: segment end.
- draw_start, output, 1 bit: one-cycle segment request.
- draw_busy, input, 1 bit: line drawer active.
- frame_err, output, 1 bit: sticky runaway flag.

Function
REQ-007 SHALL use states IDLE, FETCH, WAIT_DATA, DECODE, ISSUE, WAIT_LINE, RELEASE, REARM.
REQ-008 IDLE: SHALL hold halt=1 and go to FETCH when go=1 and draw_busy=0, with adrREAD=0 and word counter=0.
REQ-009 FETCH: SHALL present adrREAD and go to WAIT_DATA next cycle; WAIT_DATA SHALL go to DECODE next cycle (read latency 1).
REQ-010 DECODE, pos=1 and line=0: SHALL load the pen register with (x,y), increment adrREAD and the counter, and go to FETCH.
REQ-011 DECODE, line=1 and pos=0: SHALL latch x0/y0=pen and x1/y1=(x,y), set pen=(x,y), and go to ISSUE.
REQ-012 DECODE, line=1 and pos=1 (end marker): SHALL go to RELEASE.
REQ-013 DECODE, line=0 and pos=0: SHALL treat the word as no-op, increment the address, and go to FETCH.
REQ-014 ISSUE: SHALL assert draw_start for exactly one cycle only when draw_busy=0, and otherwise stay in ISSUE; it SHALL then go to WAIT_LINE.
REQ-015 WAIT_LINE: SHALL wait one cycle for draw_busy to rise, then until draw_busy=0, then increment the address and counter and go to FETCH.
REQ-016 x0/y0/x1/y1 SHALL remain stable from ISSUE until the next DECODE of a line word.
REQ-017 If the counter reaches MAX_WORDS before an end marker, the block SHALL set frame_err and go to RELEASE.
REQ-018 frame_err SHALL clear only on rst.
REQ-019 RELEASE: SHALL drive halt=0 for exactly one cycle, then go to REARM.
REQ-020 REARM: SHALL drive halt=1 and return to IDLE after go has been observed 0 at least once, so a stale go never retriggers.
REQ-021 Pen and address arithmetic SHALL wrap modulo 2^width with no saturation.
REQ-022 A go rising during any non-IDLE state SHALL be ignored.
REQ-023 go=1 with draw_busy=1 in IDLE SHALL wait in IDLE.

Reset
REQ-024 On rst, in any state including mid-segment, the block SHALL enter IDLE with:
- halt=1
- draw_start=0
- adrREAD=0
- x0/y0/x1/y1=0
- pen=(0,0)
- bank_sel=0
- frame_err=0
- counter=0

Configuration
REQ-025 With DISPLAY_DOUBLE_BUFFER_EN defined, bank_sel SHALL toggle on entry to RELEASE, and RELEASE SHALL be entered immediately on go in IDLE before drawing, so the writer fills the other bank while this bank is drawn.
REQ-026 In double-buffer mode, the block SHALL return to FETCH, not IDLE, after REARM for that frame.
REQ-027 Without DISPLAY_DOUBLE_BUFFER_EN, bank_sel SHALL be constant 0 and sequencing SHALL be single-buffer as REQ-008 to REQ-020.

Verification
REQ-028 Bench SHALL cover: list {(10,10,pos), (50,10,line), (50,40,line), end}, go=1, drawer busy 5 cycles per segment -> two draw_start pulses with (10,10)->(50,10) and (50,10)->(50,40), then one halt=0 pulse.
REQ-029 Bench SHALL cover: draw_busy=1 held 20 cycles at ISSUE -> no draw_start until draw_busy falls, then exactly one pulse.
REQ-030 Bench SHALL cover: list without end marker, MAX_WORDS=8 -> frame_err=1 after 8 words, halt=0 pulse, and frame_err stays 1 until rst.
REQ-031 Bench SHALL cover: go held 1 continuously after RELEASE -> no second frame until go drops and rises again.
REQ-032 Bench SHALL cover: rst asserted in WAIT_LINE -> next cycle all outputs at reset values and state IDLE.
REQ-033 Bench SHALL cover: DISPLAY_DOUBLE_BUFFER_EN with two frames -> bank_sel toggles 0->1->0 and one halt=0 pulse per frame.
